// File: rtl/fibo_seq_ctrl_if.sv
// Command and term-stream bundle for the Fibonacci sequencer.
// master = requester/consumer side, slave = sequencer side.
interface fibo_seq_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int SKIP_W = 8,
  parameter int CNT_W  = 8
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [SKIP_W-1:0] cmd_skip;
  logic [CNT_W-1:0]  cmd_count;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic              done;
  logic              busy;

  modport master (
    output cmd_valid,
    input  cmd_ready,
    output cmd_skip,
    output cmd_count,
    input  out_valid,
    output out_ready,
    input  out_data,
    input  out_last,
    input  done,
    input  busy
  );

  modport slave (
    input  cmd_valid,
    output cmd_ready,
    input  cmd_skip,
    input  cmd_count,
    output out_valid,
    input  out_ready,
    output out_data,
    output out_last,
    output done,
    output busy
  );
endinterface

// File: rtl/fibo_seq_ctrl.sv
// Sequencer for the Fibonacci stepper core: restart, skip
// `skip` terms, then stream `count` terms with last/done.
module fibo_seq_ctrl #(
  parameter int DATA_W = 8,
  parameter int SKIP_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  fibo_seq_ctrl_if.slave    bus,
  output logic              core_rst,
  output logic              core_hold,
  input  logic [DATA_W-1:0] core_val
);

  typedef enum logic [2:0] {
    IDLE,
    RESTART,
    SKIP,
    LOAD,
    EMIT
  } state_t;

  localparam logic [SKIP_W-1:0] SKIP_ZERO = '0;
  localparam logic [SKIP_W-1:0] SKIP_ONE  = SKIP_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ZERO  = '0;
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_TWO   = CNT_W'(2);

  state_t            state;
  state_t            state_n;
  logic [SKIP_W-1:0] skip_cnt;
  logic [CNT_W-1:0]  rem;
  logic              out_valid_q;
  logic [DATA_W-1:0] out_data_q;
  logic              out_last_q;
  logic              done_q;
  logic              accept;
  logic              fire;

  assign accept = bus.cmd_valid && (state == IDLE);
  assign fire   = out_valid_q && bus.out_ready;

  assign bus.cmd_ready = (state == IDLE);
  assign bus.busy      = (state != IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;
  assign bus.done      = done_q;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n   = state;
    core_hold = 1'b1;
    unique case (state)
      IDLE: begin
        if (accept && bus.cmd_count != CNT_ZERO)
          state_n = RESTART;
      end
      RESTART: begin
        state_n = (skip_cnt != SKIP_ZERO) ? SKIP : LOAD;
      end
      SKIP: begin
        core_hold = 1'b0;
        if (skip_cnt == SKIP_ONE) state_n = LOAD;
      end
      LOAD: begin
        state_n = EMIT;
      end
      EMIT: begin
        if (fire) begin
          if (rem == CNT_ONE) state_n = IDLE;
          else                core_hold = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // core_rst is registered so the core sees a clean one-cycle pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      skip_cnt    <= '0;
      rem         <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
      core_rst    <= 1'b1;
    end else begin
      done_q   <= 1'b0;
      core_rst <= (state_n == RESTART);
      unique case (state)
        IDLE: begin
          if (accept) begin
            skip_cnt <= bus.cmd_skip;
            rem      <= bus.cmd_count;
            if (bus.cmd_count == CNT_ZERO) done_q <= 1'b1;
          end
        end
        SKIP: begin
          skip_cnt <= skip_cnt - 1'b1;
        end
        LOAD: begin
          out_data_q  <= core_val;
          out_valid_q <= 1'b1;
          out_last_q  <= (rem == CNT_ONE);
        end
        EMIT: begin
          if (fire) begin
            if (rem == CNT_ONE) begin
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              done_q      <= 1'b1;
            end else begin
              out_data_q <= core_val;
              rem        <= rem - 1'b1;
              out_last_q <= (rem == CNT_TWO);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
